exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 SHALL have derived localparam SHAMT_W = $clog2(XLEN), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit accepts request.
REQ-007 SHALL have port in_op, input, 4, ALU operation code from cpu_defs.
REQ-008 SHALL have ports in_a and in_b, input, XLEN each, operands.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out_result, output, XLEN, ALU result.
REQ-012 SHALL have port out_taken, output, 1, branch-condition outcome.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, SHIFT, MUL, DONE.
REQ-015 SHALL assert in_ready only in IDLE, or in DONE when out_ready is high (same-cycle drain and accept).
REQ-016 SHALL capture in_op, in_a, in_b on a cycle with in_valid && in_ready.
REQ-017 ADD, SUB, AND, OR, XOR: go to DONE next cycle, latency 1; ADD/SUB wrap modulo 2^XLEN.
REQ-018 BEQ, BNE, BLT, BGE: out_result = 0, out_taken = comparison; BLT/BGE signed; latency 1.
REQ-019 SLL, SRL, SRA: shamt = in_b[SHAMT_W-1:0]; SHIFT moves one bit per cycle; latency 1+shamt; shamt 0 -> DONE next cycle with out_result = in_a.
REQ-020 SRA SHALL replicate in_a[XLEN-1]; SRL/SLL fill with 0.
REQ-021 NOP and undefined codes 4'b1101-4'b1111: out_result = 0, out_taken = 0, latency 1.
REQ-022 out_taken SHALL be 0 for all non-branch ops.
REQ-023 In DONE, out_valid = 1; out_result/out_taken SHALL hold stable until out_valid && out_ready.
REQ-024 On handshake in DONE without new request -> IDLE; with new request -> SHIFT/MUL/DONE per new op.
REQ-025 in_valid while busy SHALL be ignored (no capture, in_ready low).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, out_result 0, out_taken 0, busy 0, in_ready 0.
REQ-027 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-SHIFT/MUL SHALL discard the operation; no result is ever produced for it.

Configuration
REQ-029 Macro EXEC_UNIT_MUL_EN present: op 4'b1101 = ALU_MUL, shift-add in MUL state, one multiplier bit per cycle, latency XLEN+1, out_result = low XLEN bits of unsigned product.
REQ-030 Macro absent: MUL state and multiplier datapath not built; 4'b1101 behaves as NOP per REQ-021.

Structure
REQ-031 Package cpu_defs SHALL hold ALU op encodings, new ALU_MUL = 4'b1101, and typedef enum exec_state_t for FSM states.
REQ-032 SHALL contain one sub-module, exec_shifter: one-bit-per-step shift register, control (load, step, mode) from exec_unit FSM.
REQ-033 Comparison and single-cycle arithmetic SHALL be inline in exec_unit.

Verification
REQ-034 XLEN=32, ADD a=0xFFFFFFFF b=1 -> out_valid one cycle after accept, out_result 0x00000000, out_taken 0.
REQ-035 SRA a=0x80000000 b=4 -> out_valid after 5 cycles, out_result 0xF8000000; busy high 4 cycles.
REQ-036 BLT a=0xFFFFFFFF b=1 -> out_taken 1, out_result 0; BGE same operands -> out_taken 0.
REQ-037 Result held with out_ready low 3 cycles, in_valid high -> in_ready 0, out_result stable; out_ready high -> next op accepted same cycle.
REQ-038 rst_n low during SLL b=20 at cycle 5 -> all outputs 0 immediately, no out_valid after release.
REQ-039 With EXEC_UNIT_MUL_EN, MUL a=7 b=6 -> out_result 42 after 33 cycles; without it, same op -> out_result 0 after 1 cycle.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the execute unit: ALU op encodings, FSM state type
// and shifter mode type.
package cpu_defs;

  // ALU operation codes; 4'hD-4'hF are undefined unless EXEC_UNIT_MUL_EN claims 4'hD.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'h7;
  localparam logic [3:0] ALU_BEQ = 4'h8;
  localparam logic [3:0] ALU_BNE = 4'h9;
  localparam logic [3:0] ALU_BLT = 4'hA;
  localparam logic [3:0] ALU_BGE = 4'hB;
  localparam logic [3:0] ALU_NOP = 4'hC;
  localparam logic [3:0] ALU_MUL = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } exec_state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_t;

endpackage

// File: rtl/exec_shifter.sv
// One-bit-per-step shift register used for SLL/SRL/SRA.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   load_i        : capture data_i and mode_i
//   step_i        : shift the held value by one bit
//   mode_i        : shift direction / fill selection
//   data_i        : value to load
//   step_c_o      : combinational value after one more step (for result capture)
module exec_shifter
  import cpu_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  shift_mode_t       mode_i,
  input  logic [XLEN-1:0]   data_i,
  output logic [XLEN-1:0]   step_c_o
);

  logic [XLEN-1:0] data_q;
  shift_mode_t     mode_q;

  // Held operand and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mode_q <= SH_SLL;
    end else if (load_i) begin
      data_q <= data_i;
      mode_q <= mode_i;
    end else if (step_i) begin
      data_q <= step_c_o;
    end
  end

  // Single-bit shift; SRA replicates the sign bit
  always_comb begin
    step_c_o = data_q;
    case (mode_q)
      SH_SLL:  step_c_o = {data_q[XLEN-2:0], 1'b0};
      SH_SRL:  step_c_o = {1'b0, data_q[XLEN-1:1]};
      SH_SRA:  step_c_o = {data_q[XLEN-1], data_q[XLEN-1:1]};
      default: step_c_o = data_q;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/branch ops, iterative shifts and
// (with macro EXEC_UNIT_MUL_EN) an iterative shift-add multiplier.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake; in_op/in_a/in_b captured on accept
//   out_valid/out_ready : result handshake; out_result/out_taken held until accepted
//   busy                : FSM not in IDLE
module exec_unit
  import cpu_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            busy
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned CNT_W   = SHAMT_W + 1;

  exec_state_t       state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q;
  logic              accept;
  logic [SHAMT_W-1:0] shamt;
  logic              sh_load, sh_step;
  shift_mode_t       sh_mode;
  logic [XLEN-1:0]   sh_step_data;
`ifdef EXEC_UNIT_MUL_EN
  logic [XLEN-1:0]   mul_a_q, mul_a_d;
  logic [XLEN-1:0]   mul_b_q, mul_b_d;
  logic [XLEN-1:0]   acc_q, acc_d;
`endif

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready   = rdy_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign shamt      = in_b[SHAMT_W-1:0];
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = result_q;
  assign out_taken  = taken_q;

  exec_shifter #(.XLEN(XLEN)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (sh_load),
    .step_i   (sh_step),
    .mode_i   (sh_mode),
    .data_i   (in_a),
    .step_c_o (sh_step_data)
  );

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      taken_q  <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      cnt_q    <= cnt_d;
      rdy_q    <= 1'b1;
`ifdef EXEC_UNIT_MUL_EN
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      acc_q    <= acc_d;
`endif
    end
  end

  // Next-state, iteration and dispatch logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    taken_d  = taken_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    sh_mode  = SH_SLL;
`ifdef EXEC_UNIT_MUL_EN
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    acc_d    = acc_q;
`endif

    case (state_q)
      SHIFT: begin
        sh_step = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = sh_step_data;
        end
      end
`ifdef EXEC_UNIT_MUL_EN
      MUL: begin
        mul_a_d = {mul_a_q[XLEN-2:0], 1'b0};
        mul_b_d = {1'b0, mul_b_q[XLEN-1:1]};
        acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept only happens in IDLE or in DONE while draining, so it overrides
    if (accept) begin
      state_d  = DONE;
      result_d = '0;
      taken_d  = 1'b0;
      case (in_op)
        ALU_ADD: result_d = in_a + in_b;
        ALU_SUB: result_d = in_a - in_b;
        ALU_AND: result_d = in_a & in_b;
        ALU_OR:  result_d = in_a | in_b;
        ALU_XOR: result_d = in_a ^ in_b;
        ALU_BEQ: taken_d  = (in_a == in_b);
        ALU_BNE: taken_d  = (in_a != in_b);
        ALU_BLT: taken_d  = ($signed(in_a) <  $signed(in_b));
        ALU_BGE: taken_d  = ($signed(in_a) >= $signed(in_b));
        ALU_SLL, ALU_SRL, ALU_SRA: begin
          sh_mode = (in_op == ALU_SLL) ? SH_SLL :
                    (in_op == ALU_SRL) ? SH_SRL : SH_SRA;
          if (shamt == '0) begin
            result_d = in_a;
          end else begin
            sh_load = 1'b1;
            cnt_d   = CNT_W'(shamt);
            state_d = SHIFT;
          end
        end
`ifdef EXEC_UNIT_MUL_EN
        ALU_MUL: begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          acc_d   = '0;
          cnt_d   = CNT_W'(XLEN);
          state_d = MUL;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_taken;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_taken  (out_taken),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic taken, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.taken = taken; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Behavioural reference: result, branch outcome and latency from the op rules
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic t, output int lat);
    int sh;
    sh  = int'(b % 32);
    r   = '0;
    t   = 1'b0;
    lat = 1;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: begin r = a << sh; lat = 1 + sh; end
      ALU_SRL: begin r = a >> sh; lat = 1 + sh; end
      ALU_SRA: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
      ALU_BEQ: t = (a == b);
      ALU_BNE: t = (a != b);
      ALU_BLT: t = ($signed(a) <  $signed(b));
      ALU_BGE: t = ($signed(a) >= $signed(b));
`ifdef EXEC_UNIT_MUL_EN
      ALU_MUL: begin r = 32'(64'(a) * 64'(b)); lat = 33; end
`endif
      default: ;
    endcase
  endfunction

  // Present a request at a negedge and return at the negedge after acceptance
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("issue_ready_timeout", 64'(w), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid counting cycles since accept, then drain
  task automatic get_result(output logic [31:0] r, output logic t, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = out_result;
    t = out_taken;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] r, exp_r;
  logic        t, exp_t;
  int          lat, exp_lat;
  int          bcnt, rcnt, vcnt;
  logic [3:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    // Directed vectors
    add_vec(ALU_ADD, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0, 1);
    add_vec(ALU_SUB, 32'h0,         32'h1,          32'hFFFF_FFFF,  1'b0, 1);
    add_vec(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  1'b0, 1);
    add_vec(ALU_OR,  32'h0F0F_0000, 32'h0000_00F0,  32'h0F0F_00F0,  1'b0, 1);
    add_vec(ALU_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF,  32'h5555_5555,  1'b0, 1);
    add_vec(ALU_SRA, 32'h8000_0000, 32'h4,          32'hF800_0000,  1'b0, 5);
    add_vec(ALU_SRL, 32'h8000_0000, 32'h4,          32'h0800_0000,  1'b0, 5);
    add_vec(ALU_SLL, 32'h0000_0001, 32'd31,         32'h8000_0000,  1'b0, 32);
    add_vec(ALU_SLL, 32'h1234_5678, 32'h0,          32'h1234_5678,  1'b0, 1);
    add_vec(ALU_SRA, 32'h8000_0000, 32'h24,         32'hF800_0000,  1'b0, 5);
    add_vec(ALU_BLT, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b1, 1);
    add_vec(ALU_BGE, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0, 1);
    add_vec(ALU_BEQ, 32'h5,         32'h5,          32'h0,          1'b1, 1);
    add_vec(ALU_BNE, 32'h5,         32'h5,          32'h0,          1'b0, 1);
    add_vec(ALU_NOP, 32'h1,         32'h2,          32'h0,          1'b0, 1);
    add_vec(4'hF,    32'h1234,      32'h5678,       32'h0,          1'b0, 1);
`ifdef EXEC_UNIT_MUL_EN
    add_vec(ALU_MUL, 32'd7,         32'd6,          32'd42,         1'b0, 33);
`else
    add_vec(ALU_MUL, 32'd7,         32'd6,          32'd0,          1'b0, 1);
`endif

    // Reset state and first-edge in_ready
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_result",    64'(out_result), 64'(0));
    check("rst_taken",     64'(out_taken), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(in_ready), 64'(1));

    // Table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      get_result(r, t, lat);
      check($sformatf("vec%0d_result", i), 64'(r),   64'(vecs[i].res));
      check($sformatf("vec%0d_taken", i),  64'(t),   64'(vecs[i].taken));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // SRA by 4: busy for the shift cycles, new requests ignored meanwhile
    issue(ALU_SRA, 32'h8000_0000, 32'h4);
    in_valid = 1'b1; in_op = ALU_ADD; in_a = 32'h1; in_b = 32'h1;
    bcnt = 0; rcnt = 0; lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      if (in_ready) rcnt++;
      @(negedge clk);
      lat++;
    end
    check("sra_busy_cycles", 64'(bcnt), 64'(4));
    check("sra_ready_while_busy", 64'(rcnt), 64'(0));
    check("sra_latency", 64'(lat), 64'(5));
    check("sra_result", 64'(out_result), 64'(32'hF800_0000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Result held under backpressure, then drain-and-accept in one cycle
    issue(ALU_ADD, 32'd5, 32'd6);
    in_valid = 1'b1; in_op = ALU_XOR; in_a = 32'h0F; in_b = 32'hF0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_valid", k),  64'(out_valid),  64'(1));
      check($sformatf("hold%0d_ready", k),  64'(in_ready),   64'(0));
      check($sformatf("hold%0d_result", k), 64'(out_result), 64'(11));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("drain_next_valid",  64'(out_valid),  64'(1));
    check("drain_next_result", 64'(out_result), 64'(32'hFF));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of SLL by 20 discards the operation
    issue(ALU_SLL, 32'h1, 32'd20);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    check("mid_busy_before_rst", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  64'(out_valid),  64'(0));
    check("mid_rst_result", 64'(out_result), 64'(0));
    check("mid_rst_taken",  64'(out_taken),  64'(0));
    check("mid_rst_busy",   64'(busy),       64'(0));
    check("mid_rst_ready",  64'(in_ready),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("no_result_after_rst", 64'(vcnt), 64'(0));
    check("idle_ready_after_rst", 64'(in_ready), 64'(1));

    // Randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      model(rop, ra, rb, exp_r, exp_t, exp_lat);
      issue(rop, ra, rb);
      get_result(r, t, lat);
      check($sformatf("rnd%0d_op%0h_result", n, rop), 64'(r),   64'(exp_r));
      check($sformatf("rnd%0d_op%0h_taken", n, rop),  64'(t),   64'(exp_t));
      check($sformatf("rnd%0d_op%0h_latency", n, rop), 64'(lat), 64'(exp_lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
